demuxreg16: RTL
===============

# demuxreg16

Write-side counterpart of the 8:1 mux register. It accepts a stream of 16-bit write requests over a valid/ready handshake and holds each one in a single-entry pending stage. It then commits the request into one of eight output registers, chosen by a 3-bit select. It sits at the write-back end of the CPU pipeline and drives the eight register values back to the operand muxes, with sticky per-register write flags and a commit counter for debug.

## Interface
Parameters:
- WIDTH, 16, data width of each register and of d
- NREG, 8, number of output registers (fixed at 8; sel is 3 bits)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  write request present on d/sel
- in_ready  out  1  block can accept a request this cycle
- d  in  16  write data
- sel  in  3  destination register index 0..7
- stall  in  1  blocks commit of the pending entry
- clr_flags  in  1  clears the written[] flags
- q0..q7  out  16 each  register contents
- pending  out  1  pending stage holds an uncommitted write
- pend_sel  out  3  destination of pending write (0 when empty)
- written  out  8  sticky flag per register, set on commit
- wr_count  out  8  number of commits since reset, saturating at 255

## Operation
- The pending stage has two states:
  - EMPTY (pending=0)
  - FULL (pending=1, with hold_data and pend_sel)
- in_ready = !pending | !stall. This is combinational and has no dependence on in_valid.
- accept = in_valid & in_ready. On accept: hold_data<=d, pend_sel<=sel, pending<=1.
- commit = pending & !stall. On commit:
  - q[pend_sel]<=hold_data
  - written[pend_sel]<=1
  - wr_count<=wr_count+1, except when wr_count is already 255, where it holds at 255
- Next pending = accept ? 1 : (commit ? 0 : pending).
- State transitions:
  - EMPTY->FULL on accept.
  - FULL->EMPTY on commit without accept.
  - FULL->FULL on commit+accept, in the same cycle. The old entry commits and the new entry loads.
  - FULL with stall holds, and in_ready=0.
- When commit is 0, no q register changes. d and sel are ignored when in_valid=0.
- clr_flags clears written to 0. If a commit occurs in the same cycle, that commit's bit is set to 1, so commit wins over clear. Other bits are cleared.
- RST has priority over every other input. It sets:
  - q0..q7=0, pending=0, pend_sel=0, hold_data=0, written=0, wr_count=0
  - Any pending write in flight is discarded and is never committed.

## Timing
- Latency: a request accepted at edge N appears on q[sel] after edge N+1, provided stall=0 during cycle N+1.
- Throughput: one write per cycle while stall=0. in_ready stays 1 continuously.
- stall only delays a write; the write is never dropped. The entry commits at the first edge where stall=0.
- While stall=1 and FULL, in_ready=0, and the d/sel of a not-accepted request do not disturb hold_data.
- During the cycle RST is asserted, in_ready follows its combinational rule from the current state. In the cycle after reset it is 1.
- pending, pend_sel, q*, written and wr_count are registered outputs. Only in_ready is combinational.
- Back-to-back writes to the same sel commit in order, and the last value wins.

## Test plan
- Reset: hold RST=1 for 2 cycles with in_valid=1, d=16'hFFFF -> after release all q=0, pending=0, written=8'h00, wr_count=0, in_ready=1.
- Single write: in_valid=1, d=16'h1234, sel=5 for one cycle, stall=0 -> pending=1 after edge N, q5=16'h1234 and written=8'h20 after edge N+1, other q unchanged, wr_count=1.
- Streaming: writes d=16'hA000+i, sel=i for i=0..7 on consecutive cycles -> in_ready stays 1, after 9 edges q_i=16'hA000+i, written=8'hFF, wr_count=8.
- Stall: write d=16'hBEEF, sel=2, then stall=1 for 3 cycles with in_valid=1, d=16'h0BAD -> in_ready=0, q2 unchanged, pend_sel=2. Then stall=0 -> q2=16'hBEEF one edge later, followed by 16'h0BAD committed next.
- Clear vs commit: written=8'h0F, then clr_flags=1 on the same edge that commits sel=6 -> written=8'h40.
- Reset mid-operation plus saturation: after 300 commits wr_count=255. Then stall=1 with a pending write, and RST=1 -> pending=0, wr_count=0, the target q stays 0 after stall is released.

Source files
------------

// File: rtl/demuxreg16.sv
// Write-back demux register: a single-entry pending stage feeding eight
// registers, with sticky per-register write flags and a saturating commit count.
module demuxreg16 #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       sel,
    input  logic             stall,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7,
    output logic             pending,
    output logic [2:0]       pend_sel,
    output logic [NREG-1:0]  written,
    output logic [7:0]       wr_count
);

    typedef enum logic {EMPTY, FULL} pendState_t;

    pendState_t       state;
    pendState_t       nextState;
    logic [WIDTH-1:0] holdData;
    logic [WIDTH-1:0] qReg [NREG];
    logic [NREG-1:0]  writtenNext;
    logic             accept;
    logic             commit;

    always_ff @(posedge CLK) begin
        if (RST) state <= EMPTY;
        else     state <= nextState;
    end

    // A new request always wins the slot; an unreplaced commit drains it.
    always_comb begin
        nextState = state;
        if (accept)      nextState = FULL;
        else if (commit) nextState = EMPTY;
    end

    always_comb begin
        pending  = (state == FULL);
        in_ready = !pending || !stall;
        accept   = in_valid && in_ready;
        commit   = pending && !stall;
    end

    // Clear takes effect first so that a same-cycle commit keeps its flag.
    always_comb begin
        writtenNext = written;
        if (clr_flags) writtenNext = '0;
        if (commit)    writtenNext[pend_sel] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            holdData <= '0;
            pend_sel <= '0;
            written  <= '0;
            wr_count <= '0;
            for (int i = 0; i < NREG; i++) qReg[i] <= '0;
        end else begin
            written <= writtenNext;
            if (commit) begin
                qReg[pend_sel] <= holdData;
                if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
            end
            if (accept) begin
                holdData <= d;
                pend_sel <= sel;
            end else if (commit) begin
                pend_sel <= '0;
            end
        end
    end

    assign q0 = qReg[0];
    assign q1 = qReg[1];
    assign q2 = qReg[2];
    assign q3 = qReg[3];
    assign q4 = qReg[4];
    assign q5 = qReg[5];
    assign q6 = qReg[6];
    assign q7 = qReg[7];

endmodule
